intra_recon_sched: RTL and testbench
====================================

# intra_recon_sched

Frame-level scheduler for the intra reconstruction loop. It walks a frame's macroblocks in raster order and, per macroblock, obtains the prediction modes. It then issues luma jobs (sixteen 4x4 or one 16x16), followed by one chroma-B 8x8 job and one chroma-R 8x8 job, to the reconstructor datapath. Each job must finish before the next is issued, so neighbouring-pixel extraction always sees previously saved blocks.

## Interface
Parameters:
- WIDTH, 1280, frame width in luma pixels (multiple of 16)
- LENGTH, 720, frame height in luma pixels (multiple of 16)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- mode_req  out  1  request mode info for current MB
- mode_valid  in  1  mode info valid, sampled while mode_req=1
- mb_is4x4  in  1  1: luma uses 4x4 partition; 0: 16x16
- mode_l4  in  48  sixteen 3-bit 4x4 modes, sub-block s at bits [3s+2:3s]
- mode_l16, mode_cb, mode_cr  in  3 each  16x16 and chroma modes
- job_valid  out  1  job offered
- job_ready  in  1  datapath accepts job
- job_sel  out  2  0 luma4x4, 1 luma16x16, 2 chromaB8x8, 3 chromaR8x8
- job_mbnumber  out  32  block number for the selected path
- job_mode  out  3  prediction mode for the job
- job_done  in  1  datapath finished reconstruct+save of accepted job
- frame_done  out  1  one-cycle pulse after the last job of the frame

## Operation
- MBW=WIDTH/16, MBH=LENGTH/16, NMB=MBW*MBH (3600 at default). Counters: mb_x, mb_y, sub (0..15).
- States: IDLE, FETCH, ISSUE, WAIT, ADV.
- IDLE: outputs low; on start, clear mb_x, mb_y, sub, go FETCH.
- FETCH: mode_req=1; on mode_valid, latch all mode inputs and mb_is4x4, set phase=LUMA, sub=0, go ISSUE.
- ISSUE: job_valid=1, job fields stable until accepted; on job_ready, go WAIT.
- WAIT: on job_done, advance the phase:
  - LUMA 4x4 with sub<15: sub+1, ISSUE.
  - LUMA done (sub==15, or 16x16): phase CB, ISSUE.
  - CB: phase CR, ISSUE.
  - CR: go ADV.
- ADV: if last MB, pulse frame_done, go IDLE. Otherwise mb_x+1, wrapping to 0 with mb_y+1 at MBW-1; go FETCH.
- job_mbnumber:
  - luma4x4: (4*mb_y + sub/4)*(WIDTH/4) + 4*mb_x + sub%4. Sub-blocks are ordered in raster order inside the MB.
  - luma16x16, chroma: mb_y*MBW + mb_x.
- job_mode: mode_l4[sub], mode_l16, mode_cb or mode_cr, per the selected path.
- All arithmetic is unsigned, zero-extended to 32 bits. Multiplies are by constants only.
- Ignored inputs:
  - start outside IDLE
  - job_done outside WAIT
  - mode_valid outside FETCH
  - job_ready outside ISSUE

## Timing
- Reset (any state, mid-frame included): next cycle is IDLE. busy, mode_req, job_valid and frame_done are 0; job_sel, job_mbnumber, job_mode and all counters are 0.
- start@t → FETCH and mode_req=1 at t+1.
- mode_valid@t in FETCH → job_valid=1 at t+1.
- job_valid&job_ready@t → job_valid=0 at t+1 (WAIT).
- job_done@t → next job_valid=1 at t+1, or ADV at t+1 after CR.
- ADV@t → mode_req=1 at t+1, or frame_done=1 at t+1 with busy=0 the same cycle.
- Zero-wait handshakes:
  - 4x4 MB: 1 + 18×2 + 1 = 38 cycles.
  - 16x16 MB: 1 + 3×2 + 1 = 8 cycles.
- job_done in the same cycle as acceptance is ignored, because the block is not yet in WAIT.

## Structure
- Shared package intra_pkg:
  - job_sel enumeration (SEL_L4, SEL_L16, SEL_CB, SEL_CR)
  - state enumeration
  - 3-bit mode typedef
  - MB_LUMA=16, MB_CHROMA=8
- Optional sub-module intra_mb_addr: combinational mbnumber generation from (mb_x, mb_y, sub, sel).
- FSM and counters live in the top module.

## Test plan
All scenarios use WIDTH=32, LENGTH=32 (4 MBs) and a responder with job_ready=1 and job_done one cycle after acceptance unless noted.
- All MBs 16x16: 12 jobs in order sel 1,2,3 per MB, mbnumbers 0,0,0,1,1,1,2,2,2,3,3,3; then frame_done.
- MB0 4x4 with mode_l4 = s mod 8: luma4x4 mbnumbers 0,1,2,3,8,9,10,11,16,…,27; job_mode tracks s; then CB/CR jobs with mbnumber 0.
- MB3 4x4 (mb_x=1, mb_y=1): first luma4x4 mbnumber 36, last 63.
- Responder holds job_ready=0 for 5 cycles, then job_done delayed 7 cycles: job fields stable throughout, no extra jobs issued, stray job_done in ISSUE ignored.
- Reset asserted during WAIT of MB2: next cycle all outputs 0 and IDLE; a new start restarts at mbnumber 0.
- start pulsed while busy: no effect; frame_done exactly once per frame.

Source files
------------

// File: rtl/intra_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// intra_pkg : shared job-select, state, phase and mode types | Rev 1.0
// ---------------------------------------------------------------------------
package intra_pkg;

  typedef enum logic [1:0] {
    SEL_L4  = 2'd0,
    SEL_L16 = 2'd1,
    SEL_CB  = 2'd2,
    SEL_CR  = 2'd3
  } job_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ADV   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_LUMA = 2'd0,
    PH_CB   = 2'd1,
    PH_CR   = 2'd2
  } phase_t;

  typedef logic [2:0] mode_t;

  localparam int MB_LUMA   = 16;
  localparam int MB_CHROMA = 8;

endpackage
`default_nettype wire

// File: rtl/intra_recon_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// intra_recon_sched_if : mode-fetch and job handshake bundle | Rev 1.0
// ---------------------------------------------------------------------------
interface intra_recon_sched_if;
  import intra_pkg::*;

  logic        start;
  logic        busy;
  logic        mode_req;
  logic        mode_valid;
  logic        mb_is4x4;
  logic [47:0] mode_l4;
  mode_t       mode_l16;
  mode_t       mode_cb;
  mode_t       mode_cr;
  logic        job_valid;
  logic        job_ready;
  job_sel_t    job_sel;
  logic [31:0] job_mbnumber;
  mode_t       job_mode;
  logic        job_done;
  logic        frame_done;

  modport master (
    input  start, mode_valid, mb_is4x4, mode_l4, mode_l16, mode_cb, mode_cr,
           job_ready, job_done,
    output busy, mode_req, job_valid, job_sel, job_mbnumber, job_mode, frame_done
  );

  modport slave (
    output start, mode_valid, mb_is4x4, mode_l4, mode_l16, mode_cb, mode_cr,
           job_ready, job_done,
    input  busy, mode_req, job_valid, job_sel, job_mbnumber, job_mode, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/intra_mb_addr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// intra_mb_addr : block number for the selected reconstruction path | Rev 1.0
// ---------------------------------------------------------------------------
module intra_mb_addr
  import intra_pkg::*;
#(
  parameter int WIDTH = 1280
) (
  input  logic [15:0] mb_x,
  input  logic [15:0] mb_y,
  input  logic [3:0]  sub,
  input  job_sel_t    sel,
  output logic [31:0] mbnumber
);

  localparam logic [31:0] MBW  = 32'(WIDTH / MB_LUMA);
  localparam logic [31:0] ROW4 = 32'(WIDTH / 4);

  logic [31:0] x32;
  logic [31:0] y32;
  logic [31:0] sub_row;
  logic [31:0] sub_col;

  always_comb begin
    x32     = {16'd0, mb_x};
    y32     = {16'd0, mb_y};
    sub_row = {30'd0, sub[3:2]};
    sub_col = {30'd0, sub[1:0]};
    // 4x4 blocks are numbered across the whole frame, not within the MB
    if (sel == SEL_L4)
      mbnumber = (32'd4 * y32 + sub_row) * ROW4 + 32'd4 * x32 + sub_col;
    else
      mbnumber = y32 * MBW + x32;
  end

endmodule
`default_nettype wire

// File: rtl/intra_recon_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// intra_recon_sched : raster-order MB walker issuing luma/chroma jobs | Rev 1.0
// ---------------------------------------------------------------------------
module intra_recon_sched
  import intra_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int LENGTH = 720
) (
  input  logic               clk,
  input  logic               reset,
  intra_recon_sched_if.master bus
);

  localparam logic [15:0] MBW_M1 = 16'(WIDTH / MB_LUMA - 1);
  localparam logic [15:0] MBH_M1 = 16'(LENGTH / MB_LUMA - 1);

  state_t      state, state_nx;
  phase_t      phase, phase_nx;
  logic [15:0] mb_x, mb_x_nx;
  logic [15:0] mb_y, mb_y_nx;
  logic [3:0]  sub, sub_nx;
  logic        frame_done_q, frame_done_nx;
  logic        load_modes;

  logic        is4x4;
  logic [47:0] l4;
  mode_t       l16, cb, cr;

  job_sel_t    sel;
  logic [31:0] addr;
  logic [5:0]  l4_lsb;
  logic        last_mb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      phase        <= PH_LUMA;
      mb_x         <= '0;
      mb_y         <= '0;
      sub          <= '0;
      frame_done_q <= 1'b0;
      is4x4        <= 1'b0;
      l4           <= '0;
      l16          <= '0;
      cb           <= '0;
      cr           <= '0;
    end else begin
      state        <= state_nx;
      phase        <= phase_nx;
      mb_x         <= mb_x_nx;
      mb_y         <= mb_y_nx;
      sub          <= sub_nx;
      frame_done_q <= frame_done_nx;
      if (load_modes) begin
        is4x4 <= bus.mb_is4x4;
        l4    <= bus.mode_l4;
        l16   <= bus.mode_l16;
        cb    <= bus.mode_cb;
        cr    <= bus.mode_cr;
      end
    end
  end

  assign last_mb = (mb_x == MBW_M1) && (mb_y == MBH_M1);

  always_comb begin
    state_nx      = state;
    phase_nx      = phase;
    mb_x_nx       = mb_x;
    mb_y_nx       = mb_y;
    sub_nx        = sub;
    frame_done_nx = 1'b0;
    load_modes    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          mb_x_nx  = '0;
          mb_y_nx  = '0;
          sub_nx   = '0;
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.mode_valid) begin
          load_modes = 1'b1;
          phase_nx   = PH_LUMA;
          sub_nx     = '0;
          state_nx   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.job_ready) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.job_done) begin
          state_nx = ST_ISSUE;
          unique case (phase)
            PH_LUMA: begin
              if (is4x4 && sub != 4'd15) sub_nx   = sub + 4'd1;
              else                       phase_nx = PH_CB;
            end
            PH_CB:   phase_nx = PH_CR;
            default: state_nx = ST_ADV;
          endcase
        end
      end
      ST_ADV: begin
        if (last_mb) begin
          frame_done_nx = 1'b1;
          state_nx      = ST_IDLE;
        end else begin
          if (mb_x == MBW_M1) begin
            mb_x_nx = '0;
            mb_y_nx = mb_y + 16'd1;
          end else begin
            mb_x_nx = mb_x + 16'd1;
          end
          state_nx = ST_FETCH;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    unique case (phase)
      PH_LUMA: sel = is4x4 ? SEL_L4 : SEL_L16;
      PH_CB:   sel = SEL_CB;
      default: sel = SEL_CR;
    endcase
  end

  intra_mb_addr #(.WIDTH(WIDTH)) u_addr (
    .mb_x     (mb_x),
    .mb_y     (mb_y),
    .sub      (sub),
    .sel      (sel),
    .mbnumber (addr)
  );

  assign l4_lsb = 6'(sub) * 6'd3;

  // Job fields are forced to zero while idle so a stale frame never shows
  always_comb begin
    bus.job_sel      = SEL_L4;
    bus.job_mbnumber = '0;
    bus.job_mode     = '0;
    if (state != ST_IDLE) begin
      bus.job_sel      = sel;
      bus.job_mbnumber = addr;
      unique case (sel)
        SEL_L4:  bus.job_mode = l4[l4_lsb +: 3];
        SEL_L16: bus.job_mode = l16;
        SEL_CB:  bus.job_mode = cb;
        default: bus.job_mode = cr;
      endcase
    end
  end

  assign bus.busy       = (state != ST_IDLE);
  assign bus.mode_req   = (state == ST_FETCH);
  assign bus.job_valid  = (state == ST_ISSUE);
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_intra_recon_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_intra_recon_sched : directed 32x32-frame checks of the job scheduler | Rev 1.0
// ---------------------------------------------------------------------------
module tb_intra_recon_sched;
  import intra_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   fd_count    = 0;

  intra_recon_sched_if bus ();

  intra_recon_sched #(.WIDTH(32), .LENGTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.frame_done === 1'b1) fd_count <= fd_count + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  32'(bus.busy),         32'd0);
    chk({tag, "_req"},   32'(bus.mode_req),     32'd0);
    chk({tag, "_valid"}, 32'(bus.job_valid),    32'd0);
    chk({tag, "_fd"},    32'(bus.frame_done),   32'd0);
    chk({tag, "_sel"},   32'(bus.job_sel),      32'd0);
    chk({tag, "_mbn"},   bus.job_mbnumber,      32'd0);
    chk({tag, "_mode"},  32'(bus.job_mode),     32'd0);
  endtask

  task automatic start_frame(input string tag);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk({tag, "_start_req"},  32'(bus.mode_req), 32'd1);
    chk({tag, "_start_busy"}, 32'(bus.busy),     32'd1);
  endtask

  task automatic wait_mode_req;
    int n = 0;
    while (bus.mode_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("mode_req", 32'(bus.mode_req), 32'd1);
  endtask

  task automatic give_modes(input logic is4, input logic [47:0] l4,
                            input mode_t l16, input mode_t cb, input mode_t cr);
    bus.mb_is4x4   = is4;
    bus.mode_l4    = l4;
    bus.mode_l16   = l16;
    bus.mode_cb    = cb;
    bus.mode_cr    = cr;
    bus.mode_valid = 1'b1;
    tick;
    bus.mode_valid = 1'b0;
    // scramble inputs so only the latched copy can produce correct jobs
    bus.mb_is4x4   = ~is4;
    bus.mode_l4    = ~l4;
    bus.mode_l16   = ~l16;
    bus.mode_cb    = ~cb;
    bus.mode_cr    = ~cr;
    chk("fetch_req_low", 32'(bus.mode_req), 32'd0);
  endtask

  task automatic do_job(input string tag, input job_sel_t sel, input logic [31:0] mbn,
                        input mode_t mode, input int stall_ready, input int stall_done);
    chk({tag, "_valid"}, 32'(bus.job_valid), 32'd1);
    chk({tag, "_sel"},   32'(bus.job_sel),   32'(sel));
    chk({tag, "_mbn"},   bus.job_mbnumber,   mbn);
    chk({tag, "_mode"},  32'(bus.job_mode),  32'(mode));
    if (stall_ready > 0) begin
      bus.job_ready = 1'b0;
      bus.job_done  = 1'b1;
      for (int i = 0; i < stall_ready; i++) begin
        tick;
        chk("stall_valid", 32'(bus.job_valid), 32'd1);
        chk("stall_sel",   32'(bus.job_sel),   32'(sel));
        chk("stall_mbn",   bus.job_mbnumber,   mbn);
        chk("stall_mode",  32'(bus.job_mode),  32'(mode));
      end
      bus.job_ready = 1'b1;
    end
    tick;
    bus.job_done = 1'b0;
    chk({tag, "_wait_valid"}, 32'(bus.job_valid), 32'd0);
    for (int i = 0; i < stall_done; i++) begin
      tick;
      chk("done_wait_valid", 32'(bus.job_valid), 32'd0);
      chk("done_wait_busy",  32'(bus.busy),      32'd1);
    end
    bus.job_done = 1'b1;
    tick;
    bus.job_done = 1'b0;
  endtask

  task automatic end_mb(input bit last);
    chk("adv_busy",  32'(bus.busy),      32'd1);
    chk("adv_valid", 32'(bus.job_valid), 32'd0);
    chk("adv_req",   32'(bus.mode_req),  32'd0);
    tick;
    if (last) begin
      chk("frame_done",      32'(bus.frame_done), 32'd1);
      chk("frame_done_busy", 32'(bus.busy),       32'd0);
      tick;
      chk("frame_done_low",  32'(bus.frame_done), 32'd0);
      chk("idle_busy",       32'(bus.busy),       32'd0);
    end else begin
      chk("next_fd_low", 32'(bus.frame_done), 32'd0);
      chk("next_req",    32'(bus.mode_req),   32'd1);
    end
  endtask

  task automatic run_mb(input logic is4, input logic [47:0] l4, input mode_t l16,
                        input mode_t cb, input mode_t cr, input logic [31:0] mbn,
                        input logic [31:0] base4, input bit last);
    wait_mode_req;
    give_modes(is4, l4, l16, cb, cr);
    if (is4) begin
      for (int s = 0; s < 16; s++)
        do_job("l4", SEL_L4, base4 + 32'((s >> 2) * 8 + (s & 3)), l4[3*s +: 3], 0, 0);
    end else begin
      do_job("l16", SEL_L16, mbn, l16, 0, 0);
    end
    do_job("cb", SEL_CB, mbn, cb, 0, 0);
    do_job("cr", SEL_CR, mbn, cr, 0, 0);
    end_mb(last);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.mode_valid = 1'b0;
    bus.mb_is4x4   = 1'b0;
    bus.mode_l4    = '0;
    bus.mode_l16   = '0;
    bus.mode_cb    = '0;
    bus.mode_cr    = '0;
    bus.job_ready  = 1'b1;
    bus.job_done   = 1'b0;

    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    check_idle("rst");

    // frame 1: every MB 16x16, mbnumbers 0..3
    start_frame("f1");
    for (int m = 0; m < 4; m++)
      run_mb(1'b0, 48'd0, 3'(m), 3'(m + 3), 3'(m + 5), 32'(m), 32'd0, m == 3);

    // frame 2: MB0 and MB3 4x4, start held high during MB1
    start_frame("f2");
    run_mb(1'b1, 48'o7654321076543210, 3'd0, 3'd4, 3'd6, 32'd0, 32'd0, 1'b0);
    bus.start = 1'b1;
    run_mb(1'b0, 48'd0, 3'd2, 3'd1, 3'd7, 32'd1, 32'd0, 1'b0);
    bus.start = 1'b0;
    run_mb(1'b0, 48'd0, 3'd5, 3'd3, 3'd1, 32'd2, 32'd0, 1'b0);
    run_mb(1'b1, 48'o0123456701234567, 3'd0, 3'd2, 3'd5, 32'd3, 32'd36, 1'b1);

    // frame 3: stalled responder on MB0, then reset while waiting in MB2
    start_frame("f3");
    wait_mode_req;
    give_modes(1'b0, 48'd0, 3'd1, 3'd2, 3'd3);
    do_job("st_l16", SEL_L16, 32'd0, 3'd1, 5, 7);
    do_job("st_cb",  SEL_CB,  32'd0, 3'd2, 0, 0);
    do_job("st_cr",  SEL_CR,  32'd0, 3'd3, 0, 0);
    end_mb(1'b0);
    run_mb(1'b0, 48'd0, 3'd6, 3'd7, 3'd0, 32'd1, 32'd0, 1'b0);
    wait_mode_req;
    give_modes(1'b0, 48'd0, 3'd4, 3'd5, 3'd6);
    chk("mb2_mbn",   bus.job_mbnumber,   32'd2);
    chk("mb2_valid", 32'(bus.job_valid), 32'd1);
    tick;
    chk("mb2_wait_valid", 32'(bus.job_valid), 32'd0);
    reset = 1'b1;
    tick;
    check_idle("rst_mid");
    reset = 1'b0;
    tick;
    check_idle("rst_hold");

    // frame 4: restart after reset must begin at mbnumber 0
    start_frame("f4");
    for (int m = 0; m < 4; m++)
      run_mb(1'b0, 48'd0, 3'(m + 1), 3'(m + 2), 3'(m + 4), 32'(m), 32'd0, m == 3);

    tick;
    chk("frame_done_count", 32'(fd_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
